led_pattern_display: RTL and testbench
======================================

# led_pattern_display

Parametrised LED pattern generator: successor of the free-running binary LED counter, with configurable LED width and prescaler, four runtime-selectable display modes (binary count, running light, ping-pong, PWM breathing), a speed divider and pause. Sits at the board top level as a heartbeat/status indicator, driven directly from the system clock. Mode and speed inputs come from switches or a debug register.

## Interface
- LED_WIDTH, 8: number of LED outputs, ≥1.
- DELAY_WIDTH, 24: prescaler counter width.
- DELAY_TOP, 24'hFF_FFFF: base step period minus one, in clocks, at speed 0.
- DUTY_WIDTH, 8: breathing PWM resolution, in bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  0 = binary count, 1 = running light, 2 = ping-pong, 3 = breathing.
- speed  input  2  step period = (DELAY_TOP >> speed) + 1 clocks.
- pause  input  1  1 = freeze prescaler and pattern.
- led_data  output  LED_WIDTH  registered LED drive, 1 = on.
- step_tick  output  1  registered one-cycle pulse on each pattern step.

## Operation
- **Reset.** While rst=1 at a clock edge, all state clears: led_data=0, step_tick=0, prescaler=0, mode_q=0, pos=0, dir=up, duty=0, pwm_cnt=0.
- **Mode latch.** mode_q registers mode. When mode≠mode_q on a cycle:
  - mode_q←mode, prescaler←0, step_tick←0.
  - The pattern loads the new mode's initial value, visible on the next cycle.
  - No step occurs that cycle.
- **Prescaler.**
  - top = DELAY_TOP >> speed.
  - If cnt ≥ top: cnt←0 and a step fires. Otherwise cnt←cnt+1.
  - Using ≥ means that lowering top mid-count fires on the next cycle instead of wrapping.
- **Pause.** When pause=1, the prescaler, pattern, duty and pwm_cnt hold, and step_tick=0. A mode change still applies while paused.
- **Per-mode behaviour on each step** (initial value in brackets):
  - Mode 0 [0]: led_data←led_data+1, wrapping at 2^LED_WIDTH−1→0.
  - Mode 1 [1]: rotate left by one; the MSB wraps to bit 0.
  - Mode 2 [pos=0, dir=up]: led_data is one-hot at pos.
    - Up: pos increments until it reaches LED_WIDTH−1, then dir flips to down.
    - Down: pos decrements until it reaches 0, then dir flips to up.
    - Each end position is shown for exactly one step.
    - LED_WIDTH=1: stays at bit 0.
  - Mode 3 [duty=0, dir=up]:
    - Each step, duty moves ±1 between 0 and 2^DUTY_WIDTH−1, reversing at the ends; each end is held for one step.
    - pwm_cnt is free-running (not paused by the prescaler, held only by pause) and wraps.
    - led_data = all ones when pwm_cnt < duty, else all zeros. Duty 0 = always off; maximum duty = on for (2^DUTY_WIDTH−1)/2^DUTY_WIDTH of the time.
- **Arithmetic.** All counters are unsigned and wrap modulo their width. The shift result of top is zero-extended.

## Timing
- A step fires on the edge where cnt ≥ top. On the following cycle, led_data shows the new pattern and step_tick=1, for exactly one cycle.
- Period between step_ticks at constant speed: top+1 clocks.
- Mode change at edge N: the initial pattern is visible from N+1. The first step_tick follows top+1 clocks later.
- Reset asserted mid-operation takes effect at the next edge, with no partial step. The first step_tick after release comes DELAY_TOP+1 clocks later (speed 0).
- pause deasserting resumes counting from the held cnt. Simultaneous pause=1 and cnt ≥ top: no step, cnt holds.
- In mode 3, led_data lags pwm_cnt/duty by one register stage.

## Structure
- Shared package led_display_pkg holds:
  - mode encodings: MODE_COUNT, MODE_RUN, MODE_PINGPONG, MODE_BREATH;
  - the direction constants.
- One sub-module: led_tick_gen. It contains the prescaler, speed shift, pause handling and clear input, and produces the step strobe.
- Pattern state and output register stay in the top module.

## Test plan
Benches use DELAY_TOP=15, LED_WIDTH=4, DUTY_WIDTH=3.
- **Count and wrap.** Reset, then mode 0, speed 0 → step_tick every 16 clocks; led_data goes 0,1,2…15,0.
- **Running light.** Mode 1 → 0001, 0010, 0100, 1000, 0001 on successive ticks.
- **Ping-pong ends.** Mode 2 → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; each end is shown once.
- **Speed change.** Speed 0 with cnt=10, then set speed 2 (top=3) → step on the next cycle, then every 4 clocks.
- **Breathing.** Mode 3 at duty=3 → within each 8-clock PWM window, led_data=1111 for 3 clocks and 0000 for 5. Duty sequence 0..7..0.
- **Pause, mode change and reset mid-operation.**
  - Pause for 40 clocks → no step_tick and led_data frozen.
  - Switch mode 0→1 while paused → led_data=0001 on the next cycle.
  - Assert rst mid-count → led_data=0 and step_tick=0 at the next edge.

Source files
------------

// File: rtl/led_pattern_display_pkg.sv
// Shared encodings for the LED pattern display: mode selection and the
// direction flag used by the ping-pong and breathing patterns.
package led_display_pkg;

  localparam logic [1:0] MODE_COUNT    = 2'd0;
  localparam logic [1:0] MODE_RUN      = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_BREATH   = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pattern_display_if.sv
// Control and display signals of the LED pattern generator. The controller
// side (switches/debug register) is the master, the generator is the slave.
interface led_pattern_display_if #(
  parameter int LED_WIDTH = 8
);

  logic [1:0]           mode;
  logic [1:0]           speed;
  logic                 pause;
  logic [LED_WIDTH-1:0] led_data;
  logic                 step_tick;
  logic                 dbg_dir;

  modport master (
    output mode, speed, pause,
    input  led_data, step_tick, dbg_dir
  );

  modport slave (
    input  mode, speed, pause,
    output led_data, step_tick, dbg_dir
  );

endinterface

// File: rtl/led_pattern_display_tick_gen.sv
// Prescaler for the LED patterns: counts up to DELAY_TOP >> speed and
// raises a combinational step strobe on the cycle the count reaches top.
module led_tick_gen #(
  parameter int                     DELAY_WIDTH = 24,
  parameter logic [DELAY_WIDTH-1:0] DELAY_TOP   = 24'hFF_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic       step
);

  logic [DELAY_WIDTH-1:0] cnt;
  logic [DELAY_WIDTH-1:0] top;
  logic                   at_top;

  assign top    = DELAY_TOP >> speed;
  // >= rather than == so a speed increase mid-count fires at once.
  assign at_top = (cnt >= top);
  assign step   = !clear && !pause && at_top;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (!pause) begin
      if (at_top) cnt <= '0;
      else        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_display.sv
// Board-level heartbeat LED generator: binary count, running light,
// ping-pong and PWM breathing patterns, stepped by led_tick_gen.
module led_pattern_display
  import led_display_pkg::*;
#(
  parameter int                     LED_WIDTH   = 8,
  parameter int                     DELAY_WIDTH = 24,
  parameter logic [DELAY_WIDTH-1:0] DELAY_TOP   = 24'hFF_FFFF,
  parameter int                     DUTY_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst,
  led_pattern_display_if.slave bus
);

  localparam int                    POS_W    = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
  localparam logic [POS_W-1:0]      POS_LAST = POS_W'(LED_WIDTH - 1);
  localparam logic [DUTY_WIDTH-1:0] DUTY_MAX = '1;

  logic [1:0]            mode_q;
  logic [LED_WIDTH-1:0]  led_q;
  logic                  tick_q;
  logic [POS_W-1:0]      pos;
  logic                  dir;
  logic [DUTY_WIDTH-1:0] duty;
  logic [DUTY_WIDTH-1:0] pwm_cnt;
  logic                  mode_chg;
  logic                  step;

  logic [POS_W-1:0]      pos_nxt;
  logic                  pp_dir_nxt;
  logic [LED_WIDTH-1:0]  onehot_nxt;
  logic [DUTY_WIDTH-1:0] duty_nxt;
  logic                  br_dir_nxt;

  assign mode_chg = (bus.mode != mode_q);

  led_tick_gen #(
    .DELAY_WIDTH (DELAY_WIDTH),
    .DELAY_TOP   (DELAY_TOP)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (mode_chg),
    .pause (bus.pause),
    .speed (bus.speed),
    .step  (step)
  );

  // Direction flips on arrival at an end, so each end is shown for one step.
  always_comb begin
    pos_nxt    = pos;
    pp_dir_nxt = dir;
    if (LED_WIDTH > 1) begin
      if (dir == DIR_UP) begin
        pos_nxt = pos + 1'b1;
        if (pos_nxt == POS_LAST) pp_dir_nxt = DIR_DOWN;
      end else begin
        pos_nxt = pos - 1'b1;
        if (pos_nxt == '0) pp_dir_nxt = DIR_UP;
      end
    end
  end

  assign onehot_nxt = LED_WIDTH'(1) << pos_nxt;

  always_comb begin
    duty_nxt   = duty;
    br_dir_nxt = dir;
    if (dir == DIR_UP) begin
      duty_nxt = duty + 1'b1;
      if (duty_nxt == DUTY_MAX) br_dir_nxt = DIR_DOWN;
    end else begin
      duty_nxt = duty - 1'b1;
      if (duty_nxt == '0) br_dir_nxt = DIR_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_COUNT;
      led_q   <= '0;
      tick_q  <= 1'b0;
      pos     <= '0;
      dir     <= DIR_UP;
      duty    <= '0;
      pwm_cnt <= '0;
    end else if (mode_chg) begin
      mode_q  <= bus.mode;
      tick_q  <= 1'b0;
      pos     <= '0;
      dir     <= DIR_UP;
      duty    <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
      case (bus.mode)
        MODE_RUN, MODE_PINGPONG: led_q <= LED_WIDTH'(1);
        default:                 led_q <= '0;
      endcase
    end else if (bus.pause) begin
      tick_q <= 1'b0;
    end else begin
      tick_q  <= step;
      pwm_cnt <= pwm_cnt + 1'b1;
      case (mode_q)
        MODE_COUNT: begin
          if (step) led_q <= led_q + 1'b1;
        end
        MODE_RUN: begin
          if (step) led_q <= (led_q << 1) | (led_q >> (LED_WIDTH - 1));
        end
        MODE_PINGPONG: begin
          if (step) begin
            pos   <= pos_nxt;
            dir   <= pp_dir_nxt;
            led_q <= onehot_nxt;
          end
        end
        default: begin
          if (step) begin
            duty <= duty_nxt;
            dir  <= br_dir_nxt;
          end
          led_q <= (pwm_cnt < duty) ? '1 : '0;
        end
      endcase
    end
  end

  assign bus.led_data  = led_q;
  assign bus.step_tick = tick_q;
  assign bus.dbg_dir   = dir;

endmodule

// File: tb/tb_led_pattern_display.sv
// Directed bench for led_pattern_display with DELAY_TOP=15, LED_WIDTH=4,
// DUTY_WIDTH=3; inputs change and outputs are sampled on the falling edge.
module tb_led_pattern_display;
  import led_display_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_pattern_display_if #(.LED_WIDTH(4)) bus ();

  led_pattern_display #(
    .LED_WIDTH   (4),
    .DELAY_WIDTH (8),
    .DELAY_TOP   (8'd15),
    .DUTY_WIDTH  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic tick_wait(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.step_tick !== 1'b1 && n < 200);
    if (bus.step_tick !== 1'b1) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no step_tick within %0d clocks", n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.mode = MODE_COUNT; bus.speed = 2'd0; bus.pause = 1'b0;
    idle(3);
    checks++;
    if (bus.led_data !== 4'h0) begin errors++; $display("FAIL reset_led: got %h want 0", bus.led_data); end
    checks++;
    if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", bus.step_tick); end
    checks++;
    if (bus.dbg_dir !== DIR_UP) begin errors++; $display("FAIL reset_dir: got %b want %b", bus.dbg_dir, DIR_UP); end
    rst = 1'b0;
  endtask

  task automatic test_count;
    int n;
    logic [3:0] e;
    for (int i = 1; i <= 16; i++) begin
      tick_wait(n);
      e = i[3:0];
      checks++;
      if (n != 16) begin errors++; $display("FAIL count_period[%0d]: got %0d want 16", i, n); end
      checks++;
      if (bus.led_data !== e) begin errors++; $display("FAIL count_led[%0d]: got %h want %h", i, bus.led_data, e); end
    end
  endtask

  task automatic test_run;
    int n;
    logic [3:0] exp_v [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.mode = MODE_RUN;
    @(negedge clk);
    checks++;
    if (bus.led_data !== 4'b0001 || bus.step_tick !== 1'b0) begin
      errors++; $display("FAIL run_init: got led %b tick %b want 0001 0", bus.led_data, bus.step_tick);
    end
    for (int i = 0; i < 4; i++) begin
      tick_wait(n);
      if (i == 0) begin
        checks++;
        if (n != 16) begin errors++; $display("FAIL run_first_period: got %0d want 16", n); end
      end
      checks++;
      if (bus.led_data !== exp_v[i]) begin errors++; $display("FAIL run_led[%0d]: got %b want %b", i, bus.led_data, exp_v[i]); end
    end
  endtask

  task automatic test_pingpong;
    int n;
    logic [3:0] exp_v [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic       exp_d [7] = '{DIR_UP, DIR_UP, DIR_DOWN, DIR_DOWN, DIR_DOWN, DIR_UP, DIR_UP};
    bus.mode = MODE_PINGPONG;
    @(negedge clk);
    checks++;
    if (bus.led_data !== 4'b0001) begin errors++; $display("FAIL pp_init: got %b want 0001", bus.led_data); end
    for (int i = 0; i < 7; i++) begin
      tick_wait(n);
      checks++;
      if (bus.led_data !== exp_v[i]) begin errors++; $display("FAIL pp_led[%0d]: got %b want %b", i, bus.led_data, exp_v[i]); end
      checks++;
      if (bus.dbg_dir !== exp_d[i]) begin errors++; $display("FAIL pp_dir[%0d]: got %b want %b", i, bus.dbg_dir, exp_d[i]); end
    end
  endtask

  task automatic test_speed_change;
    int n;
    bus.mode = MODE_COUNT;
    @(negedge clk);
    checks++;
    if (bus.led_data !== 4'h0) begin errors++; $display("FAIL speed_init: got %h want 0", bus.led_data); end
    idle(10);
    bus.speed = 2'd2;
    @(negedge clk);
    checks++;
    if (bus.step_tick !== 1'b1 || bus.led_data !== 4'h1) begin
      errors++; $display("FAIL speed_immediate: got tick %b led %h want 1 1", bus.step_tick, bus.led_data);
    end
    for (int i = 2; i <= 3; i++) begin
      tick_wait(n);
      checks++;
      if (n != 4) begin errors++; $display("FAIL speed_period[%0d]: got %0d want 4", i, n); end
      checks++;
      if (bus.led_data !== 4'(i)) begin errors++; $display("FAIL speed_led[%0d]: got %h want %h", i, bus.led_data, 4'(i)); end
    end
    bus.speed = 2'd0;
  endtask

  task automatic test_breath;
    int n;
    int ones;
    int zeros;
    int exp_v [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    bus.mode = MODE_BREATH;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick_wait(n);
      ones = 0; zeros = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.led_data === 4'hF) ones++;
        else if (bus.led_data === 4'h0) zeros++;
      end
      checks++;
      if (ones != exp_v[i] || zeros != 8 - exp_v[i]) begin
        errors++; $display("FAIL breath_window[%0d]: got %0d on %0d off want %0d on %0d off",
                           i, ones, zeros, exp_v[i], 8 - exp_v[i]);
      end
    end
  endtask

  task automatic test_pause_mode;
    int n;
    int bad;
    bus.mode = MODE_COUNT;
    @(negedge clk);
    tick_wait(n);
    tick_wait(n);
    checks++;
    if (bus.led_data !== 4'h2) begin errors++; $display("FAIL pause_pre: got %h want 2", bus.led_data); end
    bus.pause = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.step_tick !== 1'b0 || bus.led_data !== 4'h2) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_frozen: got %0d bad cycles want 0", bad); end
    bus.mode = MODE_RUN;
    @(negedge clk);
    checks++;
    if (bus.led_data !== 4'b0001 || bus.step_tick !== 1'b0) begin
      errors++; $display("FAIL pause_mode_chg: got led %b tick %b want 0001 0", bus.led_data, bus.step_tick);
    end
    idle(5);
    checks++;
    if (bus.led_data !== 4'b0001) begin errors++; $display("FAIL pause_hold_run: got %b want 0001", bus.led_data); end
    bus.pause = 1'b0;
    tick_wait(n);
    checks++;
    if (n != 16 || bus.led_data !== 4'b0010) begin
      errors++; $display("FAIL pause_release: got %0d clocks led %b want 16 0010", n, bus.led_data);
    end
    idle(5);
    bus.pause = 1'b1;
    idle(10);
    bus.pause = 1'b0;
    tick_wait(n);
    checks++;
    if (n != 11 || bus.led_data !== 4'b0100) begin
      errors++; $display("FAIL pause_resume_cnt: got %0d clocks led %b want 11 0100", n, bus.led_data);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    idle(7);
    rst = 1'b1;
    bus.mode = MODE_COUNT;
    @(negedge clk);
    checks++;
    if (bus.led_data !== 4'h0 || bus.step_tick !== 1'b0) begin
      errors++; $display("FAIL midreset: got led %h tick %b want 0 0", bus.led_data, bus.step_tick);
    end
    rst = 1'b0;
    tick_wait(n);
    checks++;
    if (n != 16 || bus.led_data !== 4'h1) begin
      errors++; $display("FAIL midreset_first: got %0d clocks led %h want 16 1", n, bus.led_data);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_run();
    test_pingpong();
    test_speed_change();
    test_breath();
    test_pause_mode();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
